reg_file_sb: RTL and testbench



---
 rtl/my_pkg.sv | 11 +
 rtl/reg_file_sb_if.sv | 31 +++
 rtl/sb_popcount.sv | 18 +
 rtl/reg_file_sb.sv | 109 ++++++++++
 tb/tb_reg_file_sb.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/my_pkg.sv
// Shared constants and types for the integer register file.
package my_pkg;

  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned AW_DEF       = $clog2(NUM_REGS_DEF);

  typedef logic [AW_DEF-1:0]     reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle between issue/writeback and the register file with scoreboard.
interface reg_file_sb_if #(
  parameter int unsigned DATA_WIDTH = my_pkg::DATA_WIDTH,
  parameter int unsigned NUM_REGS   = my_pkg::NUM_REGS_DEF,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 2
);
  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam int unsigned CW = $clog2(NUM_REGS + 1);

  logic [NUM_WR-1:0]                 wr_en;
  logic [NUM_WR-1:0][AW-1:0]         addr_wr;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0] data_wr;
  logic [NUM_RD-1:0][AW-1:0]         addr_rd;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] data_rd;
  logic [NUM_RD-1:0]                 busy_rd;
  logic                              issue_en;
  logic [AW-1:0]                     issue_addr;
  logic                              flush;
  logic [CW-1:0]                     busy_cnt;

  modport master (
    output wr_en, addr_wr, data_wr, addr_rd, issue_en, issue_addr, flush,
    input  data_rd, busy_rd, busy_cnt
  );

  modport slave (
    input  wr_en, addr_wr, data_wr, addr_rd, issue_en, issue_addr, flush,
    output data_rd, busy_rd, busy_cnt
  );
endinterface

// File: rtl/sb_popcount.sv
// Combinational population count of the next-state busy vector.
module sb_popcount #(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = 6
) (
  input  logic [N-1:0]  vec_i,
  output logic [CW-1:0] cnt_c_o
);

  // Sum of set bits
  always_comb begin
    cnt_c_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      cnt_c_o = cnt_c_o + CW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with per-register busy scoreboard.
// x0 is hard-wired to zero; the highest-index write port wins collisions.
// Optional same-cycle write-to-read forwarding: define REG_FILE_BYPASS_EN.
module reg_file_sb #(
  parameter int unsigned DATA_WIDTH = my_pkg::DATA_WIDTH,
  parameter int unsigned NUM_REGS   = my_pkg::NUM_REGS_DEF,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_sb_if.slave  bus
);
  import my_pkg::*;

  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam int unsigned CW = $clog2(NUM_REGS + 1);

  logic [DATA_WIDTH-1:0]             regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]             regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]               busy_q;
  logic [NUM_REGS-1:0]               busy_d;
  logic [CW-1:0]                     busy_cnt_q;
  logic [CW-1:0]                     busy_cnt_c;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] data_rd_c;
  logic [NUM_RD-1:0]                 busy_rd_c;

  // Array next state; later ports overwrite earlier ones on a collision
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < int'(NUM_WR); i++) begin
      if (bus.wr_en[i] && (bus.addr_wr[i] != '0)) begin
        regs_d[bus.addr_wr[i]] = bus.data_wr[i];
      end
    end
  end

  // Busy next state: writeback clears, issue sets (newer producer), flush wipes all
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < int'(NUM_WR); i++) begin
      if (bus.wr_en[i] && (bus.addr_wr[i] != '0)) begin
        busy_d[bus.addr_wr[i]] = 1'b0;
      end
    end
    if (bus.issue_en && (bus.issue_addr != '0)) begin
      busy_d[bus.issue_addr] = 1'b1;
    end
    if (bus.flush) begin
      busy_d = '0;
    end
  end

  sb_popcount #(
    .N  (NUM_REGS),
    .CW (CW)
  ) u_popcount (
    .vec_i   (busy_d),
    .cnt_c_o (busy_cnt_c)
  );

  // Register array, busy vector and count share one edge so they stay consistent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        regs_q[k] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_c;
    end
  end

  // Combinational read ports with optional forwarding from the write ports
  always_comb begin
`ifdef REG_FILE_BYPASS_EN
    logic hit;
`endif
    data_rd_c = '0;
    busy_rd_c = '0;
    for (int j = 0; j < int'(NUM_RD); j++) begin
      if (bus.addr_rd[j] != '0) begin
        data_rd_c[j] = regs_q[bus.addr_rd[j]];
        busy_rd_c[j] = busy_q[bus.addr_rd[j]];
`ifdef REG_FILE_BYPASS_EN
        hit = 1'b0;
        for (int i = 0; i < int'(NUM_WR); i++) begin
          if (bus.wr_en[i] && (bus.addr_wr[i] == bus.addr_rd[j])) begin
            data_rd_c[j] = bus.data_wr[i];
            hit          = 1'b1;
          end
        end
        // Forwarded value is final unless a new producer issues to it right now
        if (hit && !(bus.issue_en && (bus.issue_addr == bus.addr_rd[j]))) begin
          busy_rd_c[j] = 1'b0;
        end
`endif
      end
    end
  end

  assign bus.data_rd  = data_rd_c;
  assign bus.busy_rd  = busy_rd_c;
  assign bus.busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scoreboard bench for reg_file_sb (both bypass configurations).
module tb_reg_file_sb;
  import my_pkg::*;

  localparam int unsigned NR = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  reg_file_sb_if #(
    .DATA_WIDTH (32),
    .NUM_REGS   (NR),
    .NUM_RD     (2),
    .NUM_WR     (2)
  ) bus ();

  reg_file_sb #(
    .DATA_WIDTH (32),
    .NUM_REGS   (NR),
    .NUM_RD     (2),
    .NUM_WR     (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int    kind;
    int    port;
    data_t data;
    logic  busy;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic idle();
    bus.wr_en    = '0;
    bus.issue_en = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input int a, input data_t d);
    bus.wr_en[p]   = 1'b1;
    bus.addr_wr[p] = 5'(a);
    bus.data_wr[p] = d;
  endtask

  task automatic issue(input int a);
    bus.issue_en   = 1'b1;
    bus.issue_addr = 5'(a);
  endtask

  task automatic exp_rd(input int p, input int a, input data_t d, input logic b, input string t);
    exp_t e;
    bus.addr_rd[p] = 5'(a);
    e.kind = 0;
    e.port = p;
    e.data = d;
    e.busy = b;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic exp_cnt(input int c, input string t);
    exp_t e;
    e.kind = 1;
    e.port = 0;
    e.data = data_t'(c);
    e.busy = 1'b0;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic compare();
    exp_t  e;
    string t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (e.kind == 0) begin
        checks++;
        assert (bus.data_rd[e.port] === e.data) else begin
          errors++;
          $error("FAIL %s data_rd[%0d]: got %08h expected %08h", t, e.port, bus.data_rd[e.port], e.data);
        end
        checks++;
        assert (bus.busy_rd[e.port] === e.busy) else begin
          errors++;
          $error("FAIL %s busy_rd[%0d]: got %0b expected %0b", t, e.port, bus.busy_rd[e.port], e.busy);
        end
      end else begin
        checks++;
        assert (bus.busy_cnt === 6'(e.data)) else begin
          errors++;
          $error("FAIL %s busy_cnt: got %0d expected %0d", t, bus.busy_cnt, e.data);
        end
      end
    end
  endtask

  task automatic check_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic check_now();
    #1;
    compare();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.wr_en      = '0;
    bus.addr_wr    = '0;
    bus.data_wr    = '0;
    bus.addr_rd    = '0;
    bus.issue_en   = 1'b0;
    bus.issue_addr = '0;
    bus.flush      = 1'b0;

    // Reset state
    exp_rd(0, 5, 32'h0, 1'b0, "rst_init_x5");
    exp_rd(1, 0, 32'h0, 1'b0, "rst_init_x0");
    exp_cnt(0, "rst_init_cnt");
    check_edge();
    #2 rst_n = 1'b1;
    cyc();

    // Write/read and x0 hard-wired
    wr(0, 3, 32'h1234_5678);
    wr(1, 0, 32'hFFFF_FFFF);
    cyc();
    idle();
    exp_rd(0, 3, 32'h1234_5678, 1'b0, "wr_x3");
    exp_rd(1, 0, 32'h0, 1'b0, "wr_x0");
    check_edge();

    // Same-address collision: port 1 wins
    wr(0, 7, 32'h1111);
    wr(1, 7, 32'h2222);
    cyc();
    idle();
    exp_rd(0, 7, 32'h2222, 1'b0, "collide_x7");
    check_edge();

    // Scoreboard set, then set-beats-clear, then plain clear
    issue(9);
    cyc();
    idle();
    cyc();
    cyc();
    exp_rd(1, 9, 32'h0, 1'b1, "issue_x9");
    exp_cnt(1, "issue_x9_cnt");
    check_edge();
    wr(0, 9, 32'hAA);
    issue(9);
    cyc();
    idle();
    exp_rd(1, 9, 32'hAA, 1'b1, "set_wins_x9");
    exp_cnt(1, "set_wins_cnt");
    check_edge();
    wr(0, 9, 32'hBB);
    cyc();
    idle();
    exp_rd(1, 9, 32'hBB, 1'b0, "clear_x9");
    exp_cnt(0, "clear_x9_cnt");
    check_edge();

    // Issue to x0 is ignored
    issue(0);
    cyc();
    idle();
    exp_rd(0, 0, 32'h0, 1'b0, "issue_x0");
    exp_cnt(0, "issue_x0_cnt");
    check_edge();

    // Flush beats issue; writes in the flush cycle land
    issue(1);
    cyc();
    issue(2);
    cyc();
    issue(4);
    cyc();
    idle();
    bus.flush = 1'b1;
    issue(6);
    wr(1, 4, 32'h55);
    exp_rd(0, 1, 32'h0, 1'b1, "pre_flush_x1");
    exp_cnt(3, "pre_flush_cnt");
    check_edge();
    cyc();
    idle();
    exp_rd(0, 4, 32'h55, 1'b0, "flush_x4");
    exp_rd(1, 6, 32'h0, 1'b0, "flush_x6");
    exp_cnt(0, "flush_cnt");
    check_edge();
    exp_rd(0, 1, 32'h0, 1'b0, "flush_x1");
    check_edge();

    // Same-cycle read of a register being written
    wr(0, 10, 32'h1234);
    issue(10);
    cyc();
    idle();
    wr(0, 10, 32'hCAFE);
`ifdef REG_FILE_BYPASS_EN
    exp_rd(0, 10, 32'hCAFE, 1'b0, "bypass_x10");
`else
    exp_rd(0, 10, 32'h1234, 1'b1, "nobypass_x10");
`endif
    exp_cnt(1, "bypass_cnt");
    check_edge();
    cyc();
    idle();
    exp_rd(0, 10, 32'hCAFE, 1'b0, "after_x10");
    exp_cnt(0, "after_x10_cnt");
    check_edge();

    // Asynchronous reset mid-run
    wr(0, 5, 32'hDEAD_BEEF);
    issue(5);
    cyc();
    idle();
    exp_rd(0, 5, 32'hDEAD_BEEF, 1'b1, "pre_rst_x5");
    exp_cnt(1, "pre_rst_cnt");
    check_edge();
    #2 rst_n = 1'b0;
    exp_rd(0, 5, 32'h0, 1'b0, "rst_x5");
    exp_rd(1, 3, 32'h0, 1'b0, "rst_x3");
    exp_cnt(0, "rst_cnt");
    check_now();
    #3 rst_n = 1'b1;
    cyc();
    exp_rd(1, 7, 32'h0, 1'b0, "post_rst_x7");
    exp_cnt(0, "post_rst_cnt");
    check_edge();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
